// File: rtl/fetch_unit_pkg.sv
// Shared constants and types for the MIPS16 instruction fetch stage.
// Holds NOP_INSTRUCT, the FETCH_RUN/FETCH_PEND state codes and the default RESET_PC.
package fetch_unit_pkg;

   localparam logic [15:0] NOP_INSTRUCT     = 16'h0800;
   localparam logic [15:0] DEFAULT_RESET_PC = 16'h0000;

   typedef enum logic {
      FETCH_RUN  = 1'b0,
      FETCH_PEND = 1'b1
   } fetch_state_t;

   typedef struct packed {
      logic [15:0] pc;
      logic [15:0] instr;
      logic        valid;
   } if_id_t;

   function automatic logic [15:0] pc_inc(input logic [15:0] p);
      return p + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: memory fetch port, stall/redirect inputs and the IF/ID register outputs.
// master = fetch unit side, slave = memory / hazard / ID side.
interface fetch_unit_if;
   logic [15:0] pc;
   logic [15:0] Instruct;
   logic        MemConflict;
   logic        noStop;
   logic        hazard_stall;
   logic        branch_taken;
   logic [15:0] branch_target;
   logic [15:0] if_id_pc;
   logic [15:0] if_id_instr;
   logic        if_id_valid;

   modport master (
      output pc, if_id_pc, if_id_instr, if_id_valid,
      input  Instruct, MemConflict, noStop, hazard_stall, branch_taken, branch_target
   );

   modport slave (
      input  pc, if_id_pc, if_id_instr, if_id_valid,
      output Instruct, MemConflict, noStop, hazard_stall, branch_taken, branch_target
   );
endinterface

// File: rtl/fetch_redirect_latch.sv
// Pending-redirect store: remembers a branch target that could not be applied yet.
// clear wins over capture, capture (newest target) wins over consume.
module fetch_redirect_latch
   import fetch_unit_pkg::*;
(
   input  logic        clk,
   input  logic        clear,
   input  logic        capture,
   input  logic        consume,
   input  logic [15:0] capture_target,
   output logic        pending,
   output logic [15:0] target
);

   fetch_state_t state_q, state_d;
   logic [15:0]  target_q;

   always_comb begin
      state_d = state_q;
      if (capture)
         state_d = FETCH_PEND;
      else if (consume)
         state_d = FETCH_RUN;
   end

   always_ff @(posedge clk) begin
      if (clear) begin
         state_q  <= FETCH_RUN;
         target_q <= 16'h0000;
      end else begin
         state_q <= state_d;
         if (capture)
            target_q <= capture_target;
      end
   end

   assign pending = (state_q == FETCH_PEND);
   assign target  = target_q;

endmodule

// File: rtl/fetch_unit.sv
// MIPS16 instruction fetch: PC register, IF/ID register, stall/bubble handling and redirects.
// Build option DELAY_SLOT_EN: the word fetched alongside a taken branch is kept (delay slot).
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC = DEFAULT_RESET_PC
) (
   input logic          clk,
   input logic          rst,
   fetch_unit_if.master bus
);

   logic [15:0] pc_q, pc_d;
   if_id_t      if_id_q, if_id_d;
   logic        hold;
   logic        capture, consume;
   logic        pend;
   logic [15:0] pend_target;
   if_id_t      bubble, fetched;

   assign hold    = !bus.noStop || bus.hazard_stall;
   assign bubble  = '{pc: pc_q, instr: NOP_INSTRUCT, valid: 1'b0};
   assign fetched = '{pc: pc_q, instr: bus.Instruct, valid: 1'b1};

   always_comb begin
      pc_d    = pc_q;
      if_id_d = if_id_q;
      capture = 1'b0;
      consume = 1'b0;
      if (hold) begin
         // pure hold: no bubble, but a redirect must not be lost
         capture = bus.branch_taken;
      end else if (bus.MemConflict) begin
         if_id_d = bubble;
`ifdef DELAY_SLOT_EN
         capture = bus.branch_taken;
`else
         if (bus.branch_taken) begin
            pc_d    = bus.branch_target;
            consume = 1'b1;
         end
`endif
      end else begin
         consume = 1'b1;
         if_id_d = fetched;
         if (bus.branch_taken)
            pc_d = bus.branch_target;
         else if (pend)
            pc_d = pend_target;
         else
            pc_d = pc_inc(pc_q);
`ifndef DELAY_SLOT_EN
         if (bus.branch_taken)
            if_id_d = bubble;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q    <= RESET_PC;
         if_id_q <= '{pc: 16'h0000, instr: NOP_INSTRUCT, valid: 1'b0};
      end else begin
         pc_q    <= pc_d;
         if_id_q <= if_id_d;
      end
   end

   fetch_redirect_latch u_redirect (
      .clk            (clk),
      .clear          (rst),
      .capture        (capture),
      .consume        (consume),
      .capture_target (bus.branch_target),
      .pending        (pend),
      .target         (pend_target)
   );

   assign bus.pc          = pc_q;
   assign bus.if_id_pc    = if_id_q.pc;
   assign bus.if_id_instr = if_id_q.instr;
   assign bus.if_id_valid = if_id_q.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; memory returns 16'h1000 + pc for every address.
module tb_fetch_unit;

   logic clk = 1'b0;
   logic rst;
   int   total  = 0;
   int   passed = 0;

   fetch_unit_if bus ();

   fetch_unit #(.RESET_PC(16'h0000)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   assign bus.Instruct = 16'h1000 + bus.pc;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic chk_ifid(input string tag, input logic [15:0] p, input logic [15:0] i,
                           input logic v);
      chk({tag, "_pc"}, bus.if_id_pc, p);
      chk({tag, "_instr"}, bus.if_id_instr, i);
      chk({tag, "_valid"}, {15'd0, bus.if_id_valid}, {15'd0, v});
   endtask

   initial begin
      rst = 1'b1;
      bus.MemConflict   = 1'b0;
      bus.noStop        = 1'b1;
      bus.hazard_stall  = 1'b0;
      bus.branch_taken  = 1'b0;
      bus.branch_target = 16'h0000;
      step();
      chk("rst_pc", bus.pc, 16'h0000);
      chk_ifid("rst", 16'h0000, 16'h0800, 1'b0);
      rst = 1'b0;

      // sequential fetch
      for (int k = 0; k < 4; k++) begin
         step();
         chk_ifid("seq", k[15:0], 16'h1000 + k[15:0], 1'b1);
      end
      chk("seq_pc", bus.pc, 16'h0004);
      step();

      // conflict bubble at pc 5
      bus.MemConflict = 1'b1;
      step();
      chk_ifid("cf_bubble", 16'h0005, 16'h0800, 1'b0);
      chk("cf_pc_hold", bus.pc, 16'h0005);
      bus.MemConflict = 1'b0;
      step();
      chk_ifid("cf_refetch", 16'h0005, 16'h1005, 1'b1);
      step();
      step();
      chk("pre_br_pc", bus.pc, 16'h0008);

      // redirect during conflict at pc 8
      bus.MemConflict   = 1'b1;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 16'h0040;
      step();
      bus.MemConflict  = 1'b0;
      bus.branch_taken = 1'b0;
`ifdef DELAY_SLOT_EN
      chk("brcf_pc", bus.pc, 16'h0008);
      step();
      chk_ifid("brcf_slot", 16'h0008, 16'h1008, 1'b1);
      chk("brcf_tgt", bus.pc, 16'h0040);
      step();
`else
      chk("brcf_pc", bus.pc, 16'h0040);
      chk("brcf_bub", {15'd0, bus.if_id_valid}, 16'h0000);
      step();
`endif
      chk_ifid("brcf_after", 16'h0040, 16'h1040, 1'b1);
      chk("brcf_pc41", bus.pc, 16'h0041);

      // freeze with redirect pulsed in
      bus.noStop        = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 16'h0100;
      for (int k = 0; k < 3; k++) begin
         step();
         bus.branch_taken = 1'b0;
         chk("frz_pc", bus.pc, 16'h0041);
         chk_ifid("frz", 16'h0040, 16'h1040, 1'b1);
      end
      bus.noStop = 1'b1;
      step();
      chk_ifid("frz_rel", 16'h0041, 16'h1041, 1'b1);
      chk("frz_tgt", bus.pc, 16'h0100);

      // freeze with reset mid-way discards the pending redirect
      bus.noStop        = 1'b0;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 16'h0200;
      step();
      bus.branch_taken = 1'b0;
      step();
      rst = 1'b1;
      step();
      chk("frst_pc", bus.pc, 16'h0000);
      chk_ifid("frst", 16'h0000, 16'h0800, 1'b0);
      rst = 1'b0;
      bus.noStop = 1'b1;
      step();
      chk("frst_nopend", bus.pc, 16'h0001);

      // hazard stall wins over conflict: pure hold
      bus.hazard_stall = 1'b1;
      bus.MemConflict  = 1'b1;
      step();
      chk_ifid("hz", 16'h0000, 16'h1000, 1'b1);
      chk("hz_pc", bus.pc, 16'h0001);
      bus.hazard_stall = 1'b0;
      bus.MemConflict  = 1'b0;

      // jump to FFFF in a normal cycle, then wrap
      bus.branch_taken  = 1'b1;
      bus.branch_target = 16'hFFFF;
      step();
      bus.branch_taken = 1'b0;
      chk("jmp_pc", bus.pc, 16'hFFFF);
`ifdef DELAY_SLOT_EN
      chk_ifid("jmp_slot", 16'h0001, 16'h1001, 1'b1);
`else
      chk_ifid("jmp_squash", 16'h0001, 16'h0800, 1'b0);
`endif
      step();
      chk("wrap_pc", bus.pc, 16'h0000);
      chk_ifid("wrap", 16'hFFFF, 16'h0FFF, 1'b1);

      // newest pending target wins
      bus.hazard_stall  = 1'b1;
      bus.branch_taken  = 1'b1;
      bus.branch_target = 16'h0010;
      step();
      bus.branch_target = 16'h0020;
      step();
      bus.hazard_stall = 1'b0;
      bus.branch_taken = 1'b0;
      step();
      chk("newest_pc", bus.pc, 16'h0020);
      chk_ifid("newest", 16'h0000, 16'h1000, 1'b1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the MIPS16 pipeline. Drives `pc` into the memory module and captures the returned `Instruct` word into the IF/ID register. Holds the PC and inserts bubbles when the memory module steals RAM1 for a data access (`MemConflict`) or freezes the machine for UART I/O (`noStop` low). Applies branch redirects from ID, remembering a redirect that arrives while fetch cannot advance.

## Interface
- `RESET_PC`, default 16'h0000: PC loaded on reset.
- `clk` in 1: CPU clock; all state updates on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `pc` out 16: fetch address to the memory module.
- `Instruct` in 16: fetched word for the current `pc`; valid at the edge when `MemConflict`=0 and `noStop`=1.
- `MemConflict` in 1: RAM1 is busy with a data access this cycle; `Instruct` is invalid.
- `noStop` in 1: 0 = memory module is in a UART sequence; whole pipeline frozen.
- `hazard_stall` in 1: load-use stall from the hazard unit; IF and ID hold.
- `branch_taken` in 1: ID resolved a taken branch/jump this cycle.
- `branch_target` in 16: redirect address, valid with `branch_taken`.
- `if_id_pc` out 16: address of the instruction in IF/ID.
- `if_id_instr` out 16: instruction in IF/ID.
- `if_id_valid` out 1: 0 = IF/ID holds an inserted bubble.

## Operation
- Events are evaluated per rising edge in strict priority order: `rst` > freeze (`noStop`=0) > `hazard_stall` > `MemConflict` > normal.
- Reset:
  - `pc`=`RESET_PC`, `if_id_pc`=0, `if_id_instr`=`NOP_INSTRUCT` (16'h0800), `if_id_valid`=0.
  - Pending-redirect flag cleared; FSM to RUN.
- Freeze and `hazard_stall`: `pc` and IF/ID hold. If `branch_taken` is high, the target is captured into the pending register (FSM to PEND).
- `MemConflict`:
  - IF/ID <= bubble (`NOP_INSTRUCT`, valid=0, `if_id_pc`=`pc`).
  - `pc` holds, so the same address is refetched.
  - `branch_taken` is captured as pending; it is not applied, because the instruction at `pc` must still be fetched.
- Normal:
  - IF/ID <= {`pc`, `Instruct`, valid=1}.
  - Next `pc` is chosen as: `branch_target` if `branch_taken`; else the pending target if in PEND (then go to RUN); else `pc`+1.
- FSM states:
  - RUN: no redirect pending.
  - PEND: redirect stored. Leaves to RUN only on a normal cycle; a stored target is never dropped by freeze or conflict.
- A new `branch_taken` while in PEND overwrites the stored target (newest wins).
- Arithmetic: `pc`+1 is 16-bit, wrapping 16'hFFFF -> 16'h0000.

## Timing
- Fetch latency is 1 cycle: the word for `pc` presented in cycle n is in IF/ID after edge n.
- Redirect: `branch_taken` at edge n means `pc`=target in cycle n+1 (normal case), or in the first normal cycle after the stall ends.
- Each `MemConflict` cycle costs exactly one bubble; there is no bubble on freeze or `hazard_stall` (pure hold).
- Reset taking effect mid-stall or in PEND discards the pending redirect.

## Configuration
- `DELAY_SLOT_EN` defined:
  - The instruction fetched in the same cycle `branch_taken` is high (the delay slot) enters IF/ID normally.
  - The pending mechanism is used exactly as in Operation.
- `DELAY_SLOT_EN` undefined:
  - A taken branch squashes the concurrently fetched word: IF/ID <= bubble and `pc` <= `branch_target`, also under `MemConflict`.
  - Under `MemConflict` the target is applied immediately; PEND is entered only from freeze or `hazard_stall`.

## Structure
- `NOP_INSTRUCT` lives in the shared `define.v` header. Add to it: `FETCH_RUN`/`FETCH_PEND` state codes and the default `RESET_PC`.
- One sub-module is natural: `fetch_redirect_latch`, holding the pending flag and target, with capture, consume and clear inputs.

## Test plan
- Sequential fetch:
  - Stimulus: reset, then `Instruct`=16'h1000+pc, no stalls for 4 cycles.
  - Required: `if_id_pc` = 0,1,2,3 and `if_id_instr` = 16'h1000..16'h1003, valid=1.
- Conflict bubble:
  - Stimulus: `MemConflict`=1 for one cycle at `pc`=5.
  - Required: IF/ID gets 16'h0800 with valid=0; `pc` stays 5; the next cycle IF/ID gets pc 5.
- Redirect during conflict (`DELAY_SLOT_EN`):
  - Stimulus: `branch_taken`=1, target 16'h0040, while `MemConflict`=1 at `pc`=8.
  - Required: pc 8 is fetched next and enters IF/ID, then `pc`=16'h0040.
- Freeze and reset:
  - Stimulus: `noStop`=0 for 3 cycles with `branch_taken` pulsed to 16'h0100.
  - Required: all outputs hold for the 3 cycles, then `pc`=16'h0100 after the first normal cycle.
  - Stimulus: repeat the freeze with `rst` asserted mid-freeze.
  - Required: `pc`=`RESET_PC` and the pending redirect is discarded.
- Hazard stall over conflict and wrap-around:
  - Stimulus: `hazard_stall`=1 together with `MemConflict`=1.
  - Required: IF/ID unchanged (no bubble).
  - Stimulus: `pc`=16'hFFFF with a normal cycle.
  - Required: next `pc`=16'h0000.
